// File: rtl/ow_serializer.sv
// ow_serializer
//   Output wrapper downstream of the IMC. Captures one result frame of
//   N_WORDS words on imc_done and streams it out word 0 first over the
//   dataReady/dataAccept handshake.
//
// Parameters
//   DW       width of one data word
//   N_WORDS  result words per frame (>=1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   imc_done    in   1-cycle pulse, imc_result valid
//   imc_result  in   frame; word k = imc_result[k*DW +: DW]
//   ow_ready    out  idle, can capture a frame
//   dataReady   out  dataOut valid
//   dataAccept  in   downstream takes dataOut this cycle
//   dataOut     out  current output word (0 while idle)
//   overflow    out  sticky: imc_done seen while busy
//   dataLast    out  final word of the frame (only with OW_LAST_EN)
//
// Configuration
//   OW_LAST_EN  defined: adds the dataLast output.
//
// All outputs are decoded from state/index/frame registers only; there is
// no combinational path from dataAccept or imc_done to any output.

module ow_serializer #(
  parameter int DW      = 16,
  parameter int N_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imc_done,
  input  logic [N_WORDS*DW-1:0] imc_result,
  output logic                  ow_ready,
  output logic                  dataReady,
  input  logic                  dataAccept,
  output logic [DW-1:0]         dataOut,
  output logic                  overflow
`ifdef OW_LAST_EN
  ,
  output logic                  dataLast
`endif
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [N_WORDS*DW-1:0]   frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (imc_done) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (dataAccept) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Frame is only written when idle; a done pulse while sending leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
    end else if (state == IDLE && imc_done) begin
      frame <= imc_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == SEND && imc_done) begin
      overflow <= 1'b1;
    end
  end

  assign ow_ready  = (state == IDLE);
  assign dataReady = (state == SEND);
  assign dataOut   = (state == SEND) ? frame[int'(idx)*DW +: DW] : '0;

`ifdef OW_LAST_EN
  assign dataLast  = (state == SEND) && (idx == LAST_IDX);
`endif

endmodule
